pixel_write_responder: RTL and testbench

//  Responder end of the 4-phase pixel-write handshake issued by the line/shape drawers
//  (pixelflag/addr/data out, pixeldone back). Captures one {x,y} + colour request,

---
 rtl/pixel_if_pkg.sv | 35 +++
 rtl/pixel_write_responder_sat_counter.sv | 19 +
 rtl/pixel_write_responder.sv | 129 ++++++++++++
 tb/tb_pixel_write_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_if_pkg.sv
// Shared definitions for the pixel-write handshake: screen limits, address
// field layout, colour type and the responder state encoding.
package pixel_if_pkg;

    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int ADDR_W       = X_W + Y_W;
    localparam int COL_W        = 16;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // A pixel is off-screen when either coordinate reaches the visible limit.
    function automatic logic is_clipped(input pix_addr_t a, input int h, input int v);
        return (int'(a.x) >= h) || (int'(a.y) >= v);
    endfunction

endpackage

// File: rtl/pixel_write_responder_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count one per inc pulse, holding at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pixel_write_responder.sv
// Responder side of the drawer pixel-write handshake. Captures one request,
// clips off-screen pixels, waits for blanking and then runs a single SRAM
// write cycle before acknowledging. Every output is a register fed from the
// current state, so strobes trail the state by one clock.
module pixel_write_responder
    import pixel_if_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int WR_CYCLES = 2,
    parameter int CNT_W     = 16
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              ipixelflag,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic [COL_W-1:0]  idata,
    input  logic              iHS,
    input  logic              iVS,
    output logic              opixeldone,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic [COL_W-1:0]  oSRAM_DQ,
    output logic              oSRAM_DQ_OE,
    output logic              oSRAM_WE_N,
    output logic              oSRAM_CE_N,
    output logic              obusy,
    output logic [CNT_W-1:0]  owrite_count,
    output logic [CNT_W-1:0]  oclip_count
);

    // Wide enough for WR_CYCLES up to 15 plus the data-hold clock.
    localparam int WC_W = 4;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wcnt;
    pix_addr_t       hold_addr;
    rgb565_t         hold_data;
    logic            win, clip, wr_done;
    logic            inc_write, inc_clip;
    logic            done_d, we_n_d, ce_n_d, oe_d, busy_d;

    // Blanking is taken straight from the timing generator's clock domain.
    assign win     = ~iHS | ~iVS;
    assign clip    = is_clipped(pix_addr_t'(iaddr), H_ACTIVE, V_ACTIVE);
    // Last WRITE clock: WR_CYCLES strobe clocks done, data-hold clock in progress.
    assign wr_done = (wcnt == WC_W'(WR_CYCLES));

    assign oSRAM_ADDR = hold_addr;
    assign oSRAM_DQ   = hold_data;

    // State register
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Clocks spent in WRITE; cleared everywhere else so each write restarts at 0
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n)              wcnt <= '0;
        else if (state == ST_WRITE) wcnt <= wcnt + 1'b1;
        else                        wcnt <= '0;
    end

    // Request capture; later changes on iaddr/idata are ignored until the next IDLE
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (state == ST_IDLE && ipixelflag) begin
            hold_addr <= pix_addr_t'(iaddr);
            hold_data <= rgb565_t'(idata);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ipixelflag) state_nxt = clip ? ST_ACK : (win ? ST_WRITE : ST_WAIT);
            ST_WAIT:  if (win)         state_nxt = ST_WRITE;
            ST_WRITE: if (wr_done)     state_nxt = ST_ACK;
            ST_ACK:   if (!ipixelflag) state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the current state, plus counter increment pulses
    always_comb begin
        done_d    = (state == ST_ACK);
        busy_d    = (state == ST_WRITE);
        ce_n_d    = (state != ST_WRITE);
        oe_d      = (state == ST_WRITE);
        we_n_d    = !((state == ST_WRITE) && (wcnt < WC_W'(WR_CYCLES)));
        inc_clip  = (state == ST_IDLE) && ipixelflag && clip;
        inc_write = (state == ST_WRITE) && wr_done;
    end

    // Output registers; reset forces the SRAM strobes inactive immediately
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            opixeldone  <= 1'b0;
            oSRAM_WE_N  <= 1'b1;
            oSRAM_CE_N  <= 1'b1;
            oSRAM_DQ_OE <= 1'b0;
            obusy       <= 1'b0;
        end else begin
            opixeldone  <= done_d;
            oSRAM_WE_N  <= we_n_d;
            oSRAM_CE_N  <= ce_n_d;
            oSRAM_DQ_OE <= oe_d;
            obusy       <= busy_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_write_cnt (
        .clk   (iclk),
        .rst_n (ireset_n),
        .inc   (inc_write),
        .count (owrite_count)
    );

    sat_counter #(.W(CNT_W)) u_clip_cnt (
        .clk   (iclk),
        .rst_n (ireset_n),
        .inc   (inc_clip),
        .count (oclip_count)
    );

endmodule

// File: tb/tb_pixel_write_responder.sv
// Scoreboard bench for pixel_write_responder: the driver pushes the expected
// response of each request, the monitor pops it on every opixeldone rise.
module tb_pixel_write_responder;

    localparam int WR = 2;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          iclk = 0;
    logic          ireset_n = 1;
    logic          ipixelflag = 0;
    logic [18:0]   iaddr = '0;
    logic [15:0]   idata = '0;
    logic          iHS = 1;
    logic          iVS = 1;
    logic          opixeldone, oSRAM_DQ_OE, oSRAM_WE_N, oSRAM_CE_N, obusy;
    logic [18:0]   oSRAM_ADDR;
    logic [15:0]   oSRAM_DQ;
    logic [CW-1:0] owrite_count, oclip_count;

    pixel_write_responder #(
        .H_ACTIVE(640), .V_ACTIVE(480), .WR_CYCLES(WR), .CNT_W(CW)
    ) dut (
        .iclk(iclk), .ireset_n(ireset_n), .ipixelflag(ipixelflag), .iaddr(iaddr),
        .idata(idata), .iHS(iHS), .iVS(iVS), .opixeldone(opixeldone),
        .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_DQ(oSRAM_DQ), .oSRAM_DQ_OE(oSRAM_DQ_OE),
        .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_CE_N(oSRAM_CE_N), .obusy(obusy),
        .owrite_count(owrite_count), .oclip_count(oclip_count)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        bit          wr;
        logic [18:0] addr;
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   n_wr = 0, n_clip = 0, exp_falls = 0, we_falls = 0;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: tracks the SRAM write of the current request, checks on done rise
    int          t0 = 0, we_len = 0;
    bit          ce_seen = 0, bus_bad = 0, flag_q = 0, done_q = 0, we_q = 1;
    logic [18:0] cap_a = '0;
    logic [15:0] cap_d = '0;
    exp_t        mon_e;

    always @(negedge iclk) begin
        if (!ireset_n) begin
            we_len = 0; ce_seen = 0; bus_bad = 0; flag_q = 0; done_q = 0; we_q = 1;
        end else begin
            if (ipixelflag && !flag_q) begin
                t0 = cyc; we_len = 0; ce_seen = 0; bus_bad = 0;
            end
            if (!oSRAM_WE_N) begin
                if (we_q) we_falls++;
                we_len++;
                cap_a = oSRAM_ADDR;
                cap_d = oSRAM_DQ;
                if (oSRAM_CE_N || !oSRAM_DQ_OE || !obusy) bus_bad = 1;
            end
            if (!oSRAM_CE_N) ce_seen = 1;
            if (opixeldone && !done_q) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("ack_bus_released", {obusy, oSRAM_CE_N, oSRAM_DQ_OE}, 3'b010);
                    if (mon_e.wr) begin
                        chk("we_len", we_len, WR);
                        chk("wr_addr", cap_a, mon_e.addr);
                        chk("wr_data", cap_d, mon_e.data);
                        chk("wr_bus_owned", bus_bad, 0);
                    end else begin
                        chk("clip_no_bus", {ce_seen, we_len != 0}, 0);
                    end
                    if (mon_e.lat >= 0) chk("latency", cyc - t0, mon_e.lat);
                end
            end
            flag_q = ipixelflag; done_q = opixeldone; we_q = oSRAM_WE_N;
        end
    end

    // Driver: queue the expectation, raise the flag, then scramble inputs
    task automatic req_start(input int x, input int y, input logic [15:0] col, input int lat);
        exp_t e;
        e.addr = {x[9:0], y[8:0]};
        e.wr   = (x < 640) && (y < 480);
        e.data = col;
        e.lat  = lat;
        sb_q.push_back(e);
        if (e.wr) begin n_wr++; exp_falls++; end
        else n_clip++;
        @(posedge iclk); #1;
        iaddr = e.addr; idata = col; ipixelflag = 1;
        @(posedge iclk); #1;
        iaddr = ~e.addr; idata = ~col;
    endtask

    task automatic wait_done(input logic v, input string nm);
        int n = 0;
        while (opixeldone !== v && n < 500) begin
            @(negedge iclk);
            n++;
        end
        if (opixeldone !== v) chk(nm, opixeldone, v);
    endtask

    task automatic req_finish(input int hold);
        wait_done(1, "done_timeout");
        repeat (hold) @(posedge iclk);
        @(posedge iclk); #1;
        ipixelflag = 0;
        wait_done(0, "done_release_timeout");
    endtask

    task automatic wait_we_low();
        int n = 0;
        while (oSRAM_WE_N && n < 50) begin
            @(negedge iclk);
            n++;
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_write_count"}, owrite_count, (n_wr > SAT) ? SAT : n_wr);
        chk({tag, "_clip_count"}, oclip_count, (n_clip > SAT) ? SAT : n_clip);
    endtask

    initial begin
        int m, n, f0, x, y;
        #1 ireset_n = 0;
        repeat (3) @(posedge iclk);
        #1;
        chk("rst_strobes", {opixeldone, oSRAM_WE_N, oSRAM_CE_N, oSRAM_DQ_OE, obusy}, 5'b01100);
        chk("rst_addr", oSRAM_ADDR, 0);
        chk("rst_dq", oSRAM_DQ, 0);
        chk_counts("rst");
        ireset_n = 1;

        // T1: blanking active, x=5 y=7 red
        iHS = 0; iVS = 1;
        req_start(5, 7, 16'hF800, WR + 3);
        req_finish(0);
        chk_counts("t1");

        // T2: no blanking for 100 clocks, then vertical sync opens the window
        iHS = 1; iVS = 1;
        req_start(100, 50, 16'h07E0, -1);
        n = 0;
        repeat (100) begin
            @(negedge iclk);
            if (obusy || !oSRAM_WE_N || !oSRAM_CE_N || opixeldone) n++;
        end
        chk("t2_idle_during_wait", n, 0);
        @(posedge iclk); #1;
        iVS = 0; m = cyc;
        wait_we_low();
        chk("t2_we_start", cyc, m + 2);
        req_finish(1);
        iVS = 1; iHS = 0;

        // T3: clipped on x and on y
        req_start(640, 0, 16'h1234, 2);
        req_finish(0);
        req_start(0, 480, 16'h5678, 2);
        req_finish(0);
        chk_counts("t3");

        // T4: window closes on the first strobe clock
        req_start(20, 30, 16'h001F, WR + 3);
        wait_we_low();
        iHS = 1; iVS = 1;
        req_finish(0);
        iHS = 0;

        // T5: 1000 writes plus interleaved clips, flag held a few clocks after done
        f0 = we_falls;
        for (int i = 0; i < 1019; i++) begin
            if (i % 51 == 50) begin
                if ((i / 51) % 2 == 1) begin x = i % 640; y = 480 + i % 32; end
                else begin x = 640 + i % 3; y = i % 480; end
                req_start(x, y, 16'(i), 2);
            end else begin
                req_start((i * 13) % 640, (i * 7) % 480, 16'(i * 37), WR + 3);
            end
            req_finish(i % 4);
        end
        chk("t5_write_pulses", we_falls - f0, 1000);
        chk_counts("t5");

        // T6: reset during the write strobe
        req_start(3, 4, 16'hABCD, WR + 3);
        wait_we_low();
        #2 ireset_n = 0;
        #1;
        chk("t6_abort", {opixeldone, oSRAM_WE_N, oSRAM_CE_N, oSRAM_DQ_OE, obusy}, 5'b01100);
        sb_q.delete();
        ipixelflag = 0;
        n_wr = 0; n_clip = 0;
        chk_counts("t6_rst");
        @(posedge iclk); #1;
        ireset_n = 1;
        req_start(9, 9, 16'h4321, WR + 3);
        req_finish(0);
        chk_counts("t6_after");

        chk("we_fall_total", we_falls, exp_falls);
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
